// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: turns EX/MEM load/store requests into one data-memory
// transaction, stalling upstream until the word returns or the bus times out.
module mem_access_stage #(
  parameter int TIMEOUT = 15,
  parameter int AW      = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  input  logic [31:0]   i_alu_data,
  input  logic [31:0]   i_st_data,
  input  logic          i_mem_rd,
  input  logic          i_mem_wr,
  input  logic [2:0]    i_funct3,
  output logic          o_dmem_req,
  output logic          o_dmem_we,
  output logic [AW-1:0] o_dmem_addr,
  output logic [31:0]   o_dmem_wdata,
  output logic [3:0]    o_dmem_bmask,
  input  logic          i_dmem_ack,
  input  logic [31:0]   i_dmem_rdata,
  output logic [31:0]   o_mem_forwarding,
  output logic [31:0]   o_ld_data,
  output logic          o_ld_valid,
  output logic          o_stall,
  output logic          o_misaligned,
  output logic          o_bus_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [3:0]    bmask_q, bmask_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic          busErr_q, busErr_d;

  logic          isMem, isWord, isHalf, aligned, start, misal;
  logic [31:0]   accData;
  logic [3:0]    accMask;
  logic [31:0]   rdShift, ldExt;
  logic          isLoadDone;

  // funct3[1] set means word, which also folds 011/110/111 into word accesses.
  assign isMem  = i_mem_rd | i_mem_wr;
  assign isWord = i_funct3[1];
  assign isHalf = ~i_funct3[1] & i_funct3[0];
  assign aligned = isWord ? (i_alu_data[1:0] == 2'b00) :
                   isHalf ? ~i_alu_data[0] : 1'b1;
  assign start  = (state_q == IDLE) & i_valid & isMem & aligned;
  assign misal  = (state_q == IDLE) & i_valid & isMem & ~aligned;

  always_comb begin
    accData = i_st_data;
    accMask = 4'b1111;
    if (isHalf) begin
      accData = {2{i_st_data[15:0]}};
      accMask = 4'b0011 << {i_alu_data[1], 1'b0};
    end else if (!isWord) begin
      accData = {4{i_st_data[7:0]}};
      accMask = 4'b0001 << i_alu_data[1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    bmask_d  = bmask_q;
    we_d     = we_q;
    f3_d     = f3_q;
    busErr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = {i_alu_data[AW-1:2], 2'b00};
          off_d   = i_alu_data[1:0];
          wdata_d = accData;
          bmask_d = accMask;
          we_d    = i_mem_wr;
          f3_d    = i_funct3;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A late ack on the timeout cycle still wins over the bus error.
        if (i_dmem_ack) begin
          rdata_d = i_dmem_rdata;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d  = 32'h0;
          busErr_d = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      off_q    <= 2'b00;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      bmask_q  <= 4'b0000;
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      busErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      bmask_q  <= bmask_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      busErr_q <= busErr_d;
    end
  end

  assign rdShift = rdata_q >> {off_q, 3'b000};

  always_comb begin
    ldExt = rdata_q;
    case (f3_q)
      3'b000:  ldExt = {{24{rdShift[7]}}, rdShift[7:0]};
      3'b100:  ldExt = {24'h0, rdShift[7:0]};
      3'b001:  ldExt = {{16{rdShift[15]}}, rdShift[15:0]};
      3'b101:  ldExt = {16'h0, rdShift[15:0]};
      default: ldExt = rdata_q;
    endcase
  end

  assign isLoadDone       = (state_q == DONE) & ~we_q;
  assign o_dmem_req       = (state_q == WAIT);
  assign o_dmem_we        = we_q;
  assign o_dmem_addr      = addr_q;
  assign o_dmem_wdata     = wdata_q;
  assign o_dmem_bmask     = bmask_q;
  assign o_ld_data        = (state_q == DONE) ? ldExt : 32'h0;
  assign o_ld_valid       = isLoadDone;
  assign o_mem_forwarding = isLoadDone ? o_ld_data : i_alu_data;
  assign o_stall          = i_rst_n & (start | (state_q == WAIT));
  assign o_misaligned     = i_rst_n & misal;
  assign o_bus_err        = busErr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed scoreboard bench for mem_access_stage: stimulus pushes expected
// responses, a negedge monitor pops them whenever the DUT presents a result.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rstN;
  logic        iValid, iMemRd, iMemWr, iDmemAck;
  logic [31:0] iAluData, iStData, iDmemRdata;
  logic [2:0]  iFunct3;
  logic        oDmemReq, oDmemWe, oLdValid, oStall, oMisaligned, oBusErr;
  logic [31:0] oDmemAddr, oDmemWdata, oMemForwarding, oLdData;
  logic [3:0]  oDmemBmask;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic        berr;
  } exp_t;

  exp_t sbQ[$];

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(15), .AW(32)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_valid(iValid), .i_alu_data(iAluData),
    .i_st_data(iStData), .i_mem_rd(iMemRd), .i_mem_wr(iMemWr), .i_funct3(iFunct3),
    .o_dmem_req(oDmemReq), .o_dmem_we(oDmemWe), .o_dmem_addr(oDmemAddr),
    .o_dmem_wdata(oDmemWdata), .o_dmem_bmask(oDmemBmask), .i_dmem_ack(iDmemAck),
    .i_dmem_rdata(iDmemRdata), .o_mem_forwarding(oMemForwarding), .o_ld_data(oLdData),
    .o_ld_valid(oLdValid), .o_stall(oStall), .o_misaligned(oMisaligned), .o_bus_err(oBusErr)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expectLoad(input logic [31:0] data, input logic berr);
    exp_t e;
    e.kind = 0; e.data = data; e.addr = 32'h0; e.mask = 4'h0; e.berr = berr;
    sbQ.push_back(e);
  endtask

  task automatic expectStore(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask);
    exp_t e;
    e.kind = 1; e.data = wdata; e.addr = addr; e.mask = mask; e.berr = 1'b0;
    sbQ.push_back(e);
  endtask

  task automatic expectMisal();
    exp_t e;
    e.kind = 2; e.data = 32'h0; e.addr = 32'h0; e.mask = 4'h0; e.berr = 1'b0;
    sbQ.push_back(e);
  endtask

  // Issue one instruction, answer with ack in WAIT cycle ackCycle (0 = never).
  task automatic applyStimulus(input string name, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] st, input logic [31:0] rdata,
                               input int ackCycle, input int expStall);
    int stallCnt = 0;
    int waitCnt  = 0;
    bit sawReq   = 1'b0;
    @(posedge clk); #1;
    iValid = 1'b1; iMemRd = rd; iMemWr = wr; iFunct3 = f3;
    iAluData = addr; iStData = st; iDmemAck = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (oDmemReq) sawReq = 1'b1;
      if (c == 0 && expStall == 0)
        checkOutput({name, " forwarding"}, oMemForwarding, addr);
      if (!oStall) break;
      stallCnt++;
      @(posedge clk); #1;
      iValid = 1'b0; iMemRd = 1'b0; iMemWr = 1'b0;
      iDmemAck = 1'b0; iDmemRdata = 32'h5A5A5A5A;
      if (oDmemReq) begin
        waitCnt++;
        if (waitCnt == ackCycle) begin
          iDmemAck = 1'b1;
          iDmemRdata = rdata;
        end
      end
    end
    @(posedge clk); #1;
    iValid = 1'b0; iMemRd = 1'b0; iMemWr = 1'b0; iDmemAck = 1'b0;
    checkOutput({name, " stall cycles"}, stallCnt, expStall);
    checkOutput({name, " request seen"}, {31'h0, sawReq}, {31'h0, expStall > 0});
  endtask

  initial begin : monitor
    exp_t e;
    logic prevReq = 1'b0;
    int evKind;
    forever begin
      @(negedge clk);
      if (rstN) begin
        evKind = -1;
        if (oLdValid) evKind = 0;
        else if (oMisaligned) evKind = 2;
        else if (oDmemReq && oDmemWe && !prevReq) evKind = 1;
        else if (oBusErr) evKind = 3;
        if (evKind >= 0) begin
          if (sbQ.size() == 0) begin
            checkOutput("unexpected output event", evKind, 32'hFFFFFFFF);
          end else begin
            e = sbQ.pop_front();
            checkOutput("event kind", evKind, e.kind);
            if (evKind == 0 && e.kind == 0) begin
              checkOutput("load data", oLdData, e.data);
              checkOutput("load forwarding", oMemForwarding, e.data);
              checkOutput("bus error", {31'h0, oBusErr}, {31'h0, e.berr});
            end else if (evKind == 1 && e.kind == 1) begin
              checkOutput("store addr", oDmemAddr, e.addr);
              checkOutput("store wdata", oDmemWdata, e.data);
              checkOutput("store bmask", {28'h0, oDmemBmask}, {28'h0, e.mask});
            end else if (evKind == 2 && e.kind == 2) begin
              checkOutput("misaligned req", {31'h0, oDmemReq}, 32'h0);
              checkOutput("misaligned stall", {31'h0, oStall}, 32'h0);
            end
          end
        end
      end
      prevReq = oDmemReq;
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int waitCnt;
    rstN = 1'b0;
    iValid = 1'b1; iMemRd = 1'b1; iMemWr = 1'b0; iFunct3 = 3'b010;
    iAluData = 32'h00000100; iStData = 32'h0; iDmemAck = 1'b0; iDmemRdata = 32'h0;
    #3;
    checkOutput("reset req", {31'h0, oDmemReq}, 32'h0);
    checkOutput("reset stall", {31'h0, oStall}, 32'h0);
    checkOutput("reset ld_valid", {31'h0, oLdValid}, 32'h0);
    checkOutput("reset bus_err", {31'h0, oBusErr}, 32'h0);
    checkOutput("reset ld_data", oLdData, 32'h0);
    checkOutput("reset forwarding", oMemForwarding, 32'h00000100);
    iValid = 1'b0; iMemRd = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;

    expectLoad(32'hDEADBEEF, 1'b0);
    applyStimulus("LW 0x100", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 2);
    expectLoad(32'hFFFFFF80, 1'b0);
    applyStimulus("LB 0x103", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 2);
    expectLoad(32'h00000080, 1'b0);
    applyStimulus("LBU 0x103", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 2, 3);
    expectLoad(32'hFFFF8011, 1'b0);
    applyStimulus("LH 0x102", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233, 1, 2);
    expectLoad(32'h00008011, 1'b0);
    applyStimulus("LHU 0x102", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80112233, 1, 2);
    expectLoad(32'h00000033, 1'b0);
    applyStimulus("LB 0x100", 1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 32'h80112233, 1, 2);
    expectStore(32'h100, 32'hABCDABCD, 4'b1100);
    applyStimulus("SH 0x102", 1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 1, 2);
    expectStore(32'h100, 32'h78787878, 4'b0010);
    applyStimulus("SB 0x101", 1'b0, 1'b1, 3'b000, 32'h101, 32'h12345678, 32'h0, 3, 4);
    expectStore(32'h104, 32'hCAFEF00D, 4'b1111);
    applyStimulus("SW rd+wr 0x104", 1'b1, 1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, 1, 2);
    expectMisal();
    applyStimulus("LW 0x101", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0);
    expectMisal();
    applyStimulus("LH 0x103", 1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 0, 0);
    expectLoad(32'h0BADF00D, 1'b0);
    applyStimulus("f3=011 0x108", 1'b1, 1'b0, 3'b011, 32'h108, 32'h0, 32'h0BADF00D, 1, 2);
    applyStimulus("non-mem", 1'b0, 1'b0, 3'b010, 32'h12345678, 32'h0, 32'h0, 0, 0);
    expectLoad(32'h00000000, 1'b1);
    applyStimulus("LW timeout", 1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, 32'h0, 0, 16);
    expectLoad(32'hFFFFFFFF, 1'b0);
    applyStimulus("LB after timeout", 1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h0000FF00, 1, 2);

    // Reset dropped in the middle of the third WAIT cycle of a load.
    @(posedge clk); #1;
    iValid = 1'b1; iMemRd = 1'b1; iFunct3 = 3'b010; iAluData = 32'h200;
    waitCnt = 0;
    for (int c = 0; c < 10 && waitCnt < 3; c++) begin
      @(posedge clk); #1;
      iValid = 1'b0; iMemRd = 1'b0; iAluData = 32'h00C0FFEE;
      if (oDmemReq) waitCnt++;
    end
    checkOutput("mid-wait cycles reached", waitCnt, 3);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("mid-wait reset req", {31'h0, oDmemReq}, 32'h0);
    checkOutput("mid-wait reset stall", {31'h0, oStall}, 32'h0);
    checkOutput("mid-wait reset ld_valid", {31'h0, oLdValid}, 32'h0);
    checkOutput("mid-wait reset ld_data", oLdData, 32'h0);
    checkOutput("mid-wait reset forwarding", oMemForwarding, 32'h00C0FFEE);
    @(posedge clk); #1;
    rstN = 1'b1;
    iDmemAck = 1'b1; iDmemRdata = 32'h11111111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("late ack req", {31'h0, oDmemReq}, 32'h0);
      checkOutput("late ack stall", {31'h0, oStall}, 32'h0);
    end
    @(posedge clk); #1;
    iDmemAck = 1'b0;
    repeat (3) @(posedge clk);
    checkOutput("scoreboard drained", sbQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameters: TIMEOUT, default 15, the number of WAIT cycles without ack before a bus error; AW, default 32, the address width.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port i_valid, input, 1 bit: the EX/MEM register holds a live instruction.
REQ-005 SHALL have port i_alu_data, input, 32 bits: the EX ALU result, used as the effective address for loads and stores.
REQ-006 SHALL have port i_st_data, input, 32 bits: the store operand (EX operand B after forwarding).
REQ-007 SHALL have ports i_mem_rd and i_mem_wr, input, 1 bit each: load or store request; both high is treated as a store.
REQ-008 SHALL have port i_funct3, input, 3 bits: access size and signedness (RV32I encoding).
REQ-009 SHALL have ports o_dmem_req, o_dmem_we, output, 1 bit each: the data memory request and write enable.
REQ-010 SHALL have ports o_dmem_addr (AW bits, word-aligned, bits [1:0]=0), o_dmem_wdata (32 bits) and o_dmem_bmask (4 bits), all outputs.
REQ-011 SHALL have ports i_dmem_ack (1 bit) and i_dmem_rdata (32 bits), both inputs: the memory completion strobe and the read word.
REQ-012 SHALL have port o_mem_forwarding, output, 32 bits: the forward value to the EX operand muxes, equal to i_alu_data when no access is in flight.
REQ-013 SHALL have port o_ld_data, output, 32 bits: the extended load result.
REQ-014 SHALL have port o_ld_valid, output, 1 bit: o_ld_data is valid this cycle.
REQ-015 SHALL have port o_stall, output, 1 bit: freeze the upstream pipeline.
REQ-016 SHALL have ports o_misaligned and o_bus_err, output, 1 bit each: exception pulses.

Function
REQ-017 SHALL implement an FSM with states IDLE, WAIT and DONE.
REQ-018 SHALL define start = (IDLE, i_valid, (i_mem_rd|i_mem_wr), aligned); aligned = word: addr[1:0]==0, half: addr[0]==0, byte: always.
REQ-019 SHALL latch the address, store data, byte mask, we and funct3 on start, and SHALL transition IDLE->WAIT.
REQ-020 SHALL drive o_stall combinationally high on start and in WAIT, and low in IDLE (no start) and in DONE.
REQ-021 SHALL hold o_dmem_req=1 and all dmem outputs stable in WAIT; o_dmem_req SHALL be 0 in IDLE and DONE.
REQ-022 SHALL, in WAIT on i_dmem_ack, register i_dmem_rdata and move to DONE; ack outside WAIT SHALL be ignored.
REQ-023 SHALL, in DONE (exactly 1 cycle), assert o_ld_valid for loads only, present o_ld_data, set o_mem_forwarding=o_ld_data for loads, then return to IDLE.
REQ-024 SHALL give a minimum latency of start-cycle + 1 WAIT cycle (ack present) + DONE, i.e. 2 stall cycles.
REQ-025 SHALL count WAIT cycles with a counter cleared on entry; on reaching TIMEOUT with no ack it SHALL pulse o_bus_err for 1 cycle, force the load data to 0 and go to DONE.
REQ-026 SHALL encode stores as: SB wdata={4{st[7:0]}}, mask=4'b0001<<addr[1:0]; SH wdata={2{st[15:0]}}, mask=4'b0011<<{addr[1],1'b0}; SW wdata=st, mask=4'b1111.
REQ-027 SHALL extract loads from the captured word by address: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-028 SHALL treat funct3 011/110/111 as a word access.
REQ-029 SHALL, on a misaligned access in IDLE with i_valid: make no request, pulse o_misaligned combinationally for that cycle, leave o_stall=0 and remain in IDLE.
REQ-030 SHALL pass non-memory instructions through in IDLE with zero stall.

Reset
REQ-031 SHALL, on i_rst_n=0 at any time including mid-WAIT, immediately set state=IDLE, counter=0 and the captured data/address=0.
REQ-032 SHALL, while in reset, drive o_dmem_req, o_ld_valid, o_bus_err, o_stall and o_ld_data to 0, and pass i_alu_data through on o_mem_forwarding.
REQ-033 SHALL cause any pending memory transaction to be abandoned on reset, with no ack captured afterward.

Verification
REQ-034 SHALL be checked: LW addr 0x100, ack in 1st WAIT cycle, rdata 0xDEADBEEF -> o_stall high 2 cycles, then o_ld_valid=1 and o_ld_data=0xDEADBEEF.
REQ-035 SHALL be checked: LB addr 0x103, rdata 0x80112233 -> 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-036 SHALL be checked: SH addr 0x102, st 0x0000ABCD -> wdata 0xABCDABCD, bmask 4'b1100, we=1, o_ld_valid stays 0.
REQ-037 SHALL be checked: LW addr 0x101 -> o_misaligned pulse, o_dmem_req never asserted, o_stall=0.
REQ-038 SHALL be checked: LW with no ack -> o_bus_err after 15 WAIT cycles, o_ld_data=0, then return to IDLE.
REQ-039 SHALL be checked: i_rst_n asserted low in the 3rd WAIT cycle -> o_dmem_req=0 immediately, and a later ack is ignored.
